// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter / period timer for an asynchronous GPIO input, result on LEDR.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int PERIOD_DIV  = 10_000,
  parameter int CNT_W       = 10
) (
  input  logic             CLOCK_50,
  input  logic [0:0]       KEY,
  input  logic [3:3]       GPIO,
  input  logic [0:0]       SW,
  output logic [CNT_W-1:0] LEDR
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(PERIOD_DIV);
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic [1:0] {RESTART, FREQ_GATE, PER_WAIT, PER_MEAS} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, m1, mode_s, mode_p;
  logic rise, mode_chg, gate_end, pre_wrap;
  logic [GW-1:0] gate_cnt;
  logic [PW-1:0] pre_cnt;
  logic [CNT_W-1:0] edge_cnt, unit_cnt, edge_inc, unit_inc;
  assign rise     = s2 & ~s3;
  assign mode_chg = mode_s ^ mode_p;
  assign gate_end = gate_cnt == GW'(GATE_CYCLES - 1);
  assign pre_wrap = pre_cnt == PW'(PERIOD_DIV - 1);
  assign edge_inc = edge_cnt + CNT_W'(rise && edge_cnt != MAX);
  // the rise cycle's own prescaler tick is included so the result is floor(period/PERIOD_DIV)
  assign unit_inc = unit_cnt + CNT_W'(pre_wrap && unit_cnt != MAX);
  always_comb begin
    state_nx = mode_chg ? RESTART :
               state == RESTART ? (mode_s ? PER_WAIT : FREQ_GATE) :
               (state == PER_WAIT && rise) ? PER_MEAS : state;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      {s1, s2, s3, m1, mode_s, mode_p} <= '0;
      state <= RESTART;
    end else begin
      s1     <= GPIO[3];
      s2     <= s1;
      s3     <= s2;
      m1     <= SW[0];
      mode_s <= m1;
      mode_p <= mode_s;
      state  <= state_nx;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      LEDR     <= '0;
      edge_cnt <= '0;
      unit_cnt <= '0;
      gate_cnt <= '0;
      pre_cnt  <= '0;
    end else if (mode_chg || state == RESTART || state == PER_WAIT) begin
      edge_cnt <= '0;
      unit_cnt <= '0;
      gate_cnt <= '0;
      pre_cnt  <= '0;
    end else if (state == FREQ_GATE) begin
      gate_cnt <= gate_end ? '0 : gate_cnt + GW'(1);
      edge_cnt <= gate_end ? '0 : edge_inc;
      if (gate_end) LEDR <= edge_inc;
    end else begin
      pre_cnt  <= (rise || pre_wrap) ? '0 : pre_cnt + PW'(1);
      unit_cnt <= rise ? '0 : unit_inc;
      if (rise) LEDR <= unit_inc;
      else if (unit_inc == MAX && unit_cnt != MAX) LEDR <= MAX;
    end
  end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed scenarios for freq_meter at GATE_CYCLES=1000, PERIOD_DIV=10 (CNT_W 10 and 6).
module tb_freq_meter;
  logic clk = 0;
  logic [0:0] key, sw;
  logic [3:3] gpio;
  logic [9:0] led;
  logic [5:0] led6;
  int checks = 0, errors = 0;
  int half = 50;
  bit run = 1;
  always #10 clk = ~clk;
  freq_meter #(.GATE_CYCLES(1000), .PERIOD_DIV(10), .CNT_W(10)) dut (
    .CLOCK_50(clk), .KEY(key), .GPIO(gpio), .SW(sw), .LEDR(led));
  freq_meter #(.GATE_CYCLES(1000), .PERIOD_DIV(10), .CNT_W(6)) dut6 (
    .CLOCK_50(clk), .KEY(key), .GPIO(gpio), .SW(sw), .LEDR(led6));
  // square wave of period 2*half cycles, frozen while run is 0
  initial begin
    gpio = '0;
    forever begin
      repeat (half) @(negedge clk);
      if (run) gpio[3] = ~gpio[3];
    end
  end
  task automatic test_reset;
    key = 0; sw = 0; half = 50; run = 1;
    repeat (5) @(negedge clk);
    checks++; if (led !== 10'd0) begin errors++; $display("FAIL reset_led got %0d want 0", led); end
    checks++; if (led6 !== 6'd0) begin errors++; $display("FAIL reset_led6 got %0d want 0", led6); end
    key = 1;
    repeat (998) @(negedge clk);
    checks++; if (led !== 10'd0) begin errors++; $display("FAIL first_gate_hold got %0d want 0", led); end
  endtask
  task automatic test_freq;
    repeat (5) @(negedge clk);
    checks++; if (led < 10'd9 || led > 10'd11) begin errors++; $display("FAIL first_gate got %0d want 9..11", led); end
    repeat (1000) @(negedge clk);
    checks++; if (led !== 10'd10) begin errors++; $display("FAIL second_gate got %0d want 10", led); end
    checks++; if (led6 !== 6'd10) begin errors++; $display("FAIL second_gate6 got %0d want 10", led6); end
  endtask
  task automatic test_freq_sat;
    half = 2;
    repeat (2100) @(negedge clk);
    checks++; if (led !== 10'd250) begin errors++; $display("FAIL freq_250 got %0d want 250", led); end
    checks++; if (led6 !== 6'd63) begin errors++; $display("FAIL freq_sat6 got %0d want 63", led6); end
  endtask
  task automatic test_period;
    sw = 1; half = 250;
    repeat (10) @(negedge clk);
    checks++; if (led !== 10'd250) begin errors++; $display("FAIL period_hold got %0d want 250", led); end
    checks++; if (led6 !== 6'd63) begin errors++; $display("FAIL period_hold6 got %0d want 63", led6); end
    repeat (1300) @(negedge clk);
    checks++; if (led !== 10'd50) begin errors++; $display("FAIL period_500 got %0d want 50", led); end
    checks++; if (led6 !== 6'd50) begin errors++; $display("FAIL period_500_6 got %0d want 50", led6); end
    repeat (500) @(negedge clk);
    checks++; if (led !== 10'd50) begin errors++; $display("FAIL period_repeat got %0d want 50", led); end
  endtask
  task automatic test_timeout;
    int n = 0;
    while (gpio[3] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (gpio[3] !== 1'b1) begin errors++; $display("FAIL wait_gpio_high got %b want 1", gpio[3]); end
    run = 0;
    repeat (10000) @(negedge clk);
    checks++; if (led !== 10'd50) begin errors++; $display("FAIL before_timeout got %0d want 50", led); end
    repeat (300) @(negedge clk);
    checks++; if (led !== 10'd1023) begin errors++; $display("FAIL timeout got %0d want 1023", led); end
    checks++; if (led6 !== 6'd63) begin errors++; $display("FAIL timeout6 got %0d want 63", led6); end
    half = 150; run = 1;
    repeat (1100) @(negedge clk);
    checks++; if (led !== 10'd30) begin errors++; $display("FAIL resume_300 got %0d want 30", led); end
    checks++; if (led6 !== 6'd30) begin errors++; $display("FAIL resume_300_6 got %0d want 30", led6); end
  endtask
  task automatic test_mode_switch;
    int n = 0;
    sw = 0; half = 25;
    while (led !== 10'd20 && n < 4000) begin @(negedge clk); n++; end
    checks++; if (led !== 10'd20) begin errors++; $display("FAIL freq_20 got %0d want 20", led); end
    repeat (500) @(negedge clk);
    sw = 1; half = 40;
    repeat (50) @(negedge clk);
    checks++; if (led !== 10'd20) begin errors++; $display("FAIL switch_hold got %0d want 20", led); end
    checks++; if (led6 !== 6'd20) begin errors++; $display("FAIL switch_hold6 got %0d want 20", led6); end
    repeat (550) @(negedge clk);
    checks++; if (led !== 10'd8) begin errors++; $display("FAIL switch_period got %0d want 8", led); end
    checks++; if (led6 !== 6'd8) begin errors++; $display("FAIL switch_period6 got %0d want 8", led6); end
  endtask
  task automatic test_mid_reset;
    key = 0;
    @(negedge clk);
    checks++; if (led !== 10'd0) begin errors++; $display("FAIL mid_reset got %0d want 0", led); end
    checks++; if (led6 !== 6'd0) begin errors++; $display("FAIL mid_reset6 got %0d want 0", led6); end
    key = 1;
    repeat (30) @(negedge clk);
    checks++; if (led !== 10'd0) begin errors++; $display("FAIL after_reset_hold got %0d want 0", led); end
    repeat (300) @(negedge clk);
    checks++; if (led !== 10'd8) begin errors++; $display("FAIL after_reset_period got %0d want 8", led); end
  endtask
  initial begin
    key = 0; sw = 0;
    test_reset;
    test_freq;
    test_freq_sat;
    test_period;
    test_timeout;
    test_mode_switch;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures an external square wave on a GPIO pin, such as the 100 Hz test clock produced on the board's GPIO header, and shows the result on the red LEDs. It runs entirely in the CLOCK_50 domain. The input pin is treated as asynchronous and is synchronised before use. There are two modes, selected by a slide switch: frequency mode (rising edges counted per gate interval) and period mode (time between rising edges, in units of PERIOD_DIV clock cycles).

## Interface
- GATE_CYCLES, 50_000_000, length of the frequency-mode gate in CLOCK_50 cycles (1 s at 50 MHz); minimum 2.
- PERIOD_DIV, 10_000, CLOCK_50 cycles per period-mode unit (200 µs at 50 MHz); minimum 2.
- CNT_W, 10, result width; the result saturates at 2^CNT_W−1.
- CLOCK_50  input  1  system clock; all logic is on its rising edge.
- KEY[0:0]  input  1  KEY[0] is the reset: synchronous, active-low.
- GPIO[3:3]  input  1  measured signal; asynchronous to CLOCK_50.
- SW[0:0]  input  1  mode select: 0 = frequency, 1 = period; asynchronous.
- LEDR[9:0]  output  CNT_W  last completed measurement.

## Operation
- **Input conditioning**
  - GPIO[3] passes through a 2-flop synchroniser (s1, s2) and then a history flop s3.
  - rise = s2 & ~s3. Only rising edges are used.
  - SW[0] passes through its own 2-flop synchroniser, giving mode_s.
- **Reset** (KEY[0]=0 sampled at a clock edge)
  - LEDR=0, and all counters are 0.
  - s1, s2 and s3 are 0; mode_s is 0.
  - State is RESTART.
  - Reset asserted mid-measurement discards the measurement in progress.
- **States:** RESTART, FREQ_GATE, PER_WAIT, PER_MEAS.
- **RESTART** (one cycle)
  - Clears the edge counter, gate counter, prescaler and unit counter.
  - Next state is FREQ_GATE if mode_s=0, else PER_WAIT.
  - LEDR is held.
- **FREQ_GATE**
  - The gate counter runs 0..GATE_CYCLES−1.
  - The edge counter increments on rise and saturates at 1023.
  - In the cycle where the gate counter equals GATE_CYCLES−1, LEDR is loaded with min(edge_count + rise, 1023). In the same cycle the edge counter is set to 0 and the gate counter wraps to 0.
  - Gates run back to back with no dead time. A rise in the terminal cycle is counted in the closing gate.
- **PER_WAIT**
  - Waits for rise, then goes to PER_MEAS with the prescaler and unit counter at 0.
- **PER_MEAS**
  - The prescaler runs 0..PERIOD_DIV−1. On wrap, the unit counter increments, saturating at 1023.
  - On rise, LEDR is loaded with the unit counter, and the prescaler and unit counter clear. The state stays PER_MEAS, so the closing edge also opens the next period.
  - If the unit counter reaches 1023 before a rise, LEDR is loaded with 1023 once; this is the timeout. The state stays PER_MEAS and the counter stays saturated until a rise.
- **Mode change:** any cycle in which mode_s differs from its value in the previous cycle forces RESTART. A partial measurement is discarded and LEDR holds its old value until the new mode produces a result.
- **Priority:** reset > mode change > measurement events.

## Timing
- A pin transition at edge k becomes visible as rise at edge k+2 (combinational from s2/s3). Counters update at edge k+3.
- Frequency-mode result latency: LEDR updates one cycle after the gate's terminal cycle.
- First frequency result: GATE_CYCLES+2 cycles after reset deassertion (RESTART + mode_s settling accounted as 2 cycles).
- Period-mode result is registered one cycle after rise.
- Period resolution:
  - Result = floor(period_cycles / PERIOD_DIV).
  - 100 Hz at 50 MHz gives 500000/10000 = 50.
  - Measurement error is ±1 unit.
- Minimum detectable input pulse width is one CLOCK_50 period. Narrower pulses may be lost.
- Maximum countable input frequency is CLOCK_50/2 (each level must be held at least one cycle).

## Test plan
Simulation uses GATE_CYCLES=1000, PERIOD_DIV=10 and a 50 MHz clock.

- **Reset, then frequency mode.** Hold KEY[0]=0 for 5 cycles. Set SW=0 and drive GPIO[3] with period 100 cycles (10 rises per gate) → LEDR=0 during reset and the first gate, then LEDR=10 (±1 on the first gate, exactly 10 thereafter), updating every 1000 cycles.
- **Frequency saturation.** Drive a 4-cycle period input (250 rises per gate) with CNT_W=6 → LEDR=63.
- **Period mode.** Set SW=1 and drive a 500-cycle period → LEDR=50 after the second rise, and 50 for every period thereafter. Result must be within 49..50.
- **Period timeout.** In period mode, stop GPIO[3] toggling after a rise → LEDR=1023 after 10230 cycles. Then resume a 300-cycle period → LEDR=30 after the next rise.
- **Mode switch mid-gate.** Toggle SW from 0 to 1 at cycle 500 of a gate → LEDR keeps its prior value with no partial frequency result. The first period result appears after two rises.
- **Mid-operation reset.** Assert KEY[0]=0 for 1 cycle during PER_MEAS → LEDR=0 on the following edge; state restarts in the mode given by SW.
